// File: rtl/imuldiv_mul_arbiter.sv
// imuldiv_mul_arbiter
// Shares one iterative multiplier between two requesters. A winning request
// is latched, issued to the multiplier, and the product is routed back to
// the requester that owns the transaction. Only one multiply is in flight.
//
// Handshake rule (all ports): a transfer fires on a rising edge where
// val && rdy. A producer holds val and msg stable until the transfer fires.
// rdy may depend combinationally on val.

module imuldiv_mul_arbiter #(
  parameter bit P_FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] req0_msg_a,
  input  logic [31:0] req0_msg_b,
  input  logic        req0_val,
  output logic        req0_rdy,
  output logic [63:0] resp0_msg_result,
  output logic        resp0_val,
  input  logic        resp0_rdy,

  input  logic [31:0] req1_msg_a,
  input  logic [31:0] req1_msg_b,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [63:0] resp1_msg_result,
  output logic        resp1_val,
  input  logic        resp1_rdy,

  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,
  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,

  output logic        busy,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_owner;
  logic        r_last_grant;
  logic        r_busy;
  logic        r_mulreq_val;

  logic        w_idle;
  logic        w_any_val;
  logic        w_grant;
  logic        w_req_fire;
  logic        w_owner_rdy;
  logic        w_resp_fire;

  // Grant selection: a lone requester wins; a tie goes to the port that was
  // not granted last (round-robin) or to port 0 (fixed priority).
  always_comb begin
    w_grant = 1'b0;
    if (req0_val && req1_val) begin
      w_grant = P_FIXED_PRIO ? 1'b0 : ~r_last_grant;
    end else if (req1_val) begin
      w_grant = 1'b1;
    end
  end

  // The reset term keeps req rdy low while reset is held, since IDLE is the
  // reset state and would otherwise advertise ready.
  assign w_idle      = (r_state == S_IDLE) && reset;
  assign w_any_val   = req0_val || req1_val;
  assign w_req_fire  = w_idle && w_any_val;
  assign w_owner_rdy = r_owner ? resp1_rdy : resp0_rdy;
  assign w_resp_fire = (r_state == S_WAIT) && mulresp_val && w_owner_rdy;

  // Request ports: only the granted, valid port sees ready.
  always_comb begin
    req0_rdy = w_idle && req0_val && (w_grant == 1'b0);
    req1_rdy = w_idle && req1_val && (w_grant == 1'b1);
  end

  // Response path: product broadcast, valid and ready steered by owner.
  always_comb begin
    resp0_msg_result = mulresp_msg_result;
    resp1_msg_result = mulresp_msg_result;
    resp0_val        = (r_state == S_WAIT) && mulresp_val && (r_owner == 1'b0);
    resp1_val        = (r_state == S_WAIT) && mulresp_val && (r_owner == 1'b1);
    mulresp_rdy      = (r_state == S_WAIT) && w_owner_rdy;
  end

  assign mulreq_msg_a = r_op_a;
  assign mulreq_msg_b = r_op_b;
  assign mulreq_val   = r_mulreq_val;
  assign busy         = r_busy;
  assign owner        = r_owner;
  assign dbg_state    = r_state;

  // Control FSM with registered busy / mulreq_val and latched operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op_a       <= 32'd0;
      r_op_b       <= 32'd0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_mulreq_val <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_op_a       <= w_grant ? req1_msg_a : req0_msg_a;
            r_op_b       <= w_grant ? req1_msg_b : req0_msg_b;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_busy       <= 1'b1;
            r_mulreq_val <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mulreq_rdy) begin
            r_mulreq_val <= 1'b0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_resp_fire) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy       <= 1'b0;
          r_mulreq_val <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Bench for imuldiv_mul_arbiter: directed steps plus a random phase, with a
// cycle-stepped multiplier stub, request sources and response sinks.
module tb_imuldiv_mul_arbiter;

  localparam bit FIXED = 1'b0;
  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_RESP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [63:0] resp0_msg_result, resp1_msg_result;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [31:0] mulreq_msg_a, mulreq_msg_b;
  logic        mulreq_val, mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val, mulresp_rdy;
  logic        busy, owner;
  logic [1:0]  dbg_state;

  imuldiv_mul_arbiter #(.P_FIXED_PRIO(FIXED)) dut (
    .clk(clk), .reset(reset),
    .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
    .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
    .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  logic [63:0] src_q0[$];
  logic [63:0] src_q1[$];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] mulop_q[$];
  int          grant_log[$];
  logic [1:0]  src_held;
  logic [63:0] src_cur0, src_cur1;
  bit          src_rand, sink_rand, mul_rand, spur, hold0;
  int          mul_st, mul_cnt;
  logic [63:0] mul_prod;
  bit          m_busy, m_issued, m_owner, m_last;
  int          n_vec, n_err;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  task automatic push(input int p, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] e);
    if (p == 0) begin src_q0.push_back({a, b}); exp_q0.push_back(e); end
    else        begin src_q1.push_back({a, b}); exp_q1.push_back(e); end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle();
    logic eg;
    logic [63:0] ab, e;
    @(negedge clk);
    if (!src_held[0] && src_q0.size() > 0 && (!src_rand || $urandom_range(0, 2) == 0)) begin
      src_held[0] = 1'b1; src_cur0 = src_q0[0];
    end
    if (!src_held[1] && src_q1.size() > 0 && (!src_rand || $urandom_range(0, 2) == 0)) begin
      src_held[1] = 1'b1; src_cur1 = src_q1[0];
    end
    req0_val = src_held[0];
    {req0_msg_a, req0_msg_b} = src_held[0] ? src_cur0 : {$urandom, $urandom};
    req1_val = src_held[1];
    {req1_msg_a, req1_msg_b} = src_held[1] ? src_cur1 : {$urandom, $urandom};
    resp0_rdy = hold0 ? 1'b0 : (sink_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    resp1_rdy = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mul_st == M_BUSY && mul_cnt == 0) mul_st = M_RESP;
    mulreq_rdy = (mul_st == M_IDLE) && (!mul_rand || $urandom_range(0, 1) == 1);
    if (mul_st == M_RESP) begin
      mulresp_val = 1'b1; mulresp_msg_result = mul_prod;
    end else if (mul_st == M_IDLE && spur) begin
      mulresp_val = 1'($urandom_range(0, 1)); mulresp_msg_result = {$urandom, $urandom};
    end else begin
      mulresp_val = 1'b0; mulresp_msg_result = {$urandom, $urandom};
    end
    #1;
    // per-cycle observations against the bench model
    chk("busy", busy, m_busy);
    if (m_busy) chk("owner", owner, m_owner);
    chk("mulreq_val", mulreq_val, m_busy && !m_issued);
    chk("resp0_val", resp0_val, mul_st == M_RESP && m_owner == 1'b0);
    chk("resp1_val", resp1_val, mul_st == M_RESP && m_owner == 1'b1);
    chk("mulresp_rdy", mulresp_rdy, mul_st != M_IDLE && (m_owner ? resp1_rdy : resp0_rdy));
    if (!m_busy) begin
      eg = (req0_val && req1_val) ? (FIXED ? 1'b0 : ~m_last) : req1_val;
      chk("req0_rdy", req0_rdy, (req0_val || req1_val) && !eg);
      chk("req1_rdy", req1_rdy, (req0_val || req1_val) && eg);
    end else begin
      chk("req0_rdy_busy", req0_rdy, 0);
      chk("req1_rdy_busy", req1_rdy, 0);
    end
    chk("mulresp_fire", mulresp_val && mulresp_rdy,
        (resp0_val && resp0_rdy) || (resp1_val && resp1_rdy));
    // transfers that fire at the coming rising edge
    if (req0_val && req0_rdy) begin
      grant_log.push_back(0); mulop_q.push_back(src_cur0); void'(src_q0.pop_front());
      src_held[0] = 1'b0; m_busy = 1'b1; m_issued = 1'b0; m_owner = 1'b0; m_last = 1'b0;
    end else if (req1_val && req1_rdy) begin
      grant_log.push_back(1); mulop_q.push_back(src_cur1); void'(src_q1.pop_front());
      src_held[1] = 1'b0; m_busy = 1'b1; m_issued = 1'b0; m_owner = 1'b1; m_last = 1'b1;
    end
    if (mulreq_val && mulreq_rdy) begin
      ab = (mulop_q.size() > 0) ? mulop_q.pop_front() : 64'd0;
      chk("mulreq_ops", {mulreq_msg_a, mulreq_msg_b}, ab);
      mul_prod = smul(mulreq_msg_a, mulreq_msg_b);
      mul_st = M_BUSY; mul_cnt = mul_rand ? $urandom_range(0, 4) : 0; m_issued = 1'b1;
    end
    if (resp0_val && resp0_rdy) begin
      if (exp_q0.size() == 0) chk("resp0_extra", resp0_val, 0);
      else begin e = exp_q0.pop_front(); chk("resp0_result", resp0_msg_result, e); end
    end
    if (resp1_val && resp1_rdy) begin
      if (exp_q1.size() == 0) chk("resp1_extra", resp1_val, 0);
      else begin e = exp_q1.pop_front(); chk("resp1_result", resp1_msg_result, e); end
    end
    if (mulresp_val && mulresp_rdy && mul_st == M_RESP) begin
      mul_st = M_IDLE; m_busy = 1'b0;
    end
    if (mul_st == M_BUSY && mul_cnt > 0) mul_cnt--;
  endtask

  task automatic drain(input int max, output bit done);
    int n;
    n = 0;
    while ((src_q0.size() > 0 || src_q1.size() > 0 || exp_q0.size() > 0 ||
            exp_q1.size() > 0 || m_busy) && n < max) begin
      cycle(); n++;
    end
    done = !(src_q0.size() > 0 || src_q1.size() > 0 || exp_q0.size() > 0 ||
             exp_q1.size() > 0 || m_busy);
  endtask

  task automatic wait_resp(input int max, output bit seen);
    int n;
    n = 0;
    while (!(mul_st == M_RESP && m_busy) && n < max) begin cycle(); n++; end
    seen = (mul_st == M_RESP && m_busy);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit done;
    logic [31:0] ra, rb;
    n_vec = 0; n_err = 0;
    src_held = 2'b00; src_cur0 = '0; src_cur1 = '0;
    src_rand = 0; sink_rand = 0; mul_rand = 0; spur = 0; hold0 = 0;
    mul_st = M_IDLE; mul_cnt = 0; mul_prod = '0;
    m_busy = 0; m_issued = 0; m_owner = 0; m_last = 1;
    req0_msg_a = '0; req0_msg_b = '0; req1_msg_a = '0; req1_msg_b = '0;
    resp0_rdy = 1; resp1_rdy = 1; mulreq_rdy = 1;
    mulresp_msg_result = '0; mulresp_val = 1;
    req0_val = 1; req1_val = 1;
    reset = 0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_req0_rdy", req0_rdy, 0);
    chk("rst_req1_rdy", req1_rdy, 0);
    chk("rst_mulreq_val", mulreq_val, 0);
    chk("rst_mulresp_rdy", mulresp_rdy, 0);
    chk("rst_resp0_val", resp0_val, 0);
    chk("rst_resp1_val", resp1_val, 0);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    req0_val = 0; req1_val = 0; mulresp_val = 0;
    reset = 1;

    // 1: port 0 alone, spurious multiplier responses while idle
    spur = 1;
    push(0, 32'h00000008, 32'h00000003, 64'h00000000_00000018);
    drain(100, done); chk("t1_done", done, 1);
    spur = 0;

    // 2: port 1 alone, negative operand
    push(1, 32'hfffffff8, 32'h00000008, 64'hffffffff_ffffffc0);
    drain(100, done); chk("t2_done", done, 1);

    // 3: both ports continuously valid, alternating grants
    grant_log.delete();
    push(0, 32'h00000001, 32'h00000001, 64'h00000000_00000001);
    push(0, 32'h00000002, 32'h00000003, 64'h00000000_00000006);
    push(0, 32'h7fffffff, 32'h00000002, 64'h00000000_fffffffe);
    push(0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    push(1, 32'hffffffff, 32'hffffffff, 64'h00000000_00000001);
    push(1, 32'h00000005, 32'hfffffffd, 64'hffffffff_fffffff1);
    push(1, 32'h00010000, 32'h00010000, 64'h00000001_00000000);
    push(1, 32'hffffffff, 32'h7fffffff, 64'hffffffff_80000001);
    drain(200, done); chk("t3_done", done, 1);
    chk("t3_grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) chk($sformatf("t3_grant%0d", i), grant_log[i], i % 2);

    // 4: random delays everywhere
    src_rand = 1; sink_rand = 1; mul_rand = 1;
    push(0, 32'h0deadbee, 32'h10000000, 64'h00deadbe_e0000000);
    push(1, 32'hdeadbeef, 32'h10000000, 64'hfdeadbee_f0000000);
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; push(0, ra, rb, smul(ra, rb));
      ra = $urandom; rb = $urandom; push(1, ra, rb, smul(ra, rb));
    end
    drain(5000, done); chk("t4_done", done, 1);
    src_rand = 0; sink_rand = 0; mul_rand = 0;

    // 5: owner backpressure for 20 cycles
    hold0 = 1;
    push(0, 32'h12345678, 32'h00000010, 64'h00000001_23456780);
    wait_resp(50, done); chk("t5_reach_wait", done, 1);
    push(1, 32'h00000003, 32'h00000004, 64'h00000000_0000000c);
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("t5_mulresp_rdy", mulresp_rdy, 0);
      chk("t5_busy", busy, 1);
      chk("t5_req0_rdy", req0_rdy, 0);
      chk("t5_req1_rdy", req1_rdy, 0);
    end
    hold0 = 0;
    drain(100, done); chk("t5_done", done, 1);

    // 6: reset during WAIT, then first tie goes to port 0
    hold0 = 1;
    push(0, 32'h00000006, 32'h00000007, 64'h00000000_0000002a);
    wait_resp(50, done); chk("t6_reach_wait", done, 1);
    chk("t6_pre_resp0_val", resp0_val, 1);
    req0_val = 1; req1_val = 1;
    #1 reset = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_mulreq_val", mulreq_val, 0);
    chk("t6_resp0_val", resp0_val, 0);
    chk("t6_resp1_val", resp1_val, 0);
    chk("t6_req0_rdy", req0_rdy, 0);
    chk("t6_req1_rdy", req1_rdy, 0);
    chk("t6_mulresp_rdy", mulresp_rdy, 0);
    src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete(); mulop_q.delete();
    src_held = 2'b00; mul_st = M_IDLE; mulresp_val = 0; hold0 = 0;
    m_busy = 0; m_issued = 0; m_owner = 0; m_last = 1;
    req0_val = 0; req1_val = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    grant_log.delete();
    push(0, 32'h00000001, 32'h00000002, 64'h00000000_00000002);
    push(1, 32'h00000003, 32'h00000003, 64'h00000000_00000009);
    drain(100, done); chk("t6_done", done, 1);
    chk("t6_grant_count", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("t6_first_grant", grant_log[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imuldiv_mul_arbiter.md
Name: imuldiv_mul_arbiter

Overview:
- Shares one iterative multiplier (val/rdy request and response ports) between two requesters, for example two pipeline ports.
- Arbitrates among valid requests, with round-robin or fixed priority.
- Latches the winning operands and issues them to the multiplier.
- Routes the 64-bit result back to the requester that owns the transaction. Exactly one multiply is outstanding at any time.

Parameters:
- P_FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins a tie.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- req0_msg_a  in  32  port 0 operand a
- req0_msg_b  in  32  port 0 operand b
- req0_val  in  1  port 0 request valid
- req0_rdy  out  1  port 0 request ready
- resp0_msg_result  out  64  port 0 product
- resp0_val  out  1  port 0 response valid
- resp0_rdy  in  1  port 0 response ready
- req1_msg_a / req1_msg_b / req1_val / req1_rdy  as port 0, for port 1
- resp1_msg_result / resp1_val / resp1_rdy  as port 0, for port 1
- mulreq_msg_a  out  32  operand a to multiplier
- mulreq_msg_b  out  32  operand b to multiplier
- mulreq_val  out  1  multiplier request valid
- mulreq_rdy  in  1  multiplier request ready
- mulresp_msg_result  in  64  multiplier product
- mulresp_val  in  1  multiplier response valid
- mulresp_rdy  out  1  multiplier response ready
- busy  out  1  1 whenever the FSM is not in IDLE
- owner  out  1  port index that owns the current transaction

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - state=IDLE; opA, opB, owner cleared to 0; last_grant=1, so port 0 wins the first tie.
  - While reset is asserted, every val/rdy output and busy are forced to 0.
  - Reset asserted mid-transaction abandons the transaction; the multiplier is reset on the same reset net.
- A transfer fires on any cycle where val && rdy.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Grant selection:
    - Only one reqN_val is high: grant = N.
    - Both are high, round-robin (P_FIXED_PRIO=0): grant = ~last_grant.
    - Both are high, P_FIXED_PRIO=1: grant = 0.
  - reqN_rdy = 1 only for the granted port and only when that port's val is high; the losing port sees rdy = 0.
  - On fire: latch a, b and owner=grant; last_grant <= grant; next state ISSUE.
  - With no valid request, the FSM stays in IDLE.
- ISSUE:
  - mulreq_val=1; mulreq_msg_a/b driven from the opA/opB registers, which stay stable until the transfer fires.
  - On mulreq_rdy: next state WAIT. Otherwise stay in ISSUE.
  - req0_rdy = req1_rdy = 0.
- WAIT:
  - Product path is combinational: resp0_msg_result = resp1_msg_result = mulresp_msg_result (broadcast to both ports).
  - resp[owner]_val = mulresp_val; the other port's resp_val = 0.
  - mulresp_rdy = resp[owner]_rdy.
  - On fire: next state IDLE.
  - The response holds, with backpressure, for as long as the owner keeps rdy low.
- Outside WAIT: mulresp_rdy=0 and both resp_val=0. A spurious mulresp_val is ignored.
- Latency:
  - Request accepted at cycle t; mulreq fires no earlier than t+1.
  - The response reaches the requester in the same cycle the multiplier presents it.
  - The next request can be accepted in the cycle after the response fires. This gives a minimum of 2 cycles of arbiter overhead per operation.
- Fairness: round-robin never grants one port twice in a row while the other port is continuously valid.
- Arithmetic: none inside this block. Operands and product pass unmodified; the signed 32x32->64 multiply is the multiplier's job.
- owner stays stable from request acceptance until the response fires.

Test Plan:
1. Port 0 only, a=0x00000008, b=0x00000003 -> resp0 result 0x00000000_00000018; resp1_val never asserted.
2. Port 1 only, a=0xfffffff8, b=0x00000008 -> resp1 result 0xffffffff_ffffffc0; owner=1 throughout.
3. Both ports valid every cycle, 4 ops each, P_FIXED_PRIO=0:
   - Grant order is 0,1,0,1,...
   - Port 0 receives 0x00000000_00000001 from 1*1; port 1 receives 0x00000000_00000001 from 0xffffffff*0xffffffff.
   - Each port receives exactly its own results.
4. Random source and sink delays on both ports, the multiplier and the responses; vectors include 0x0deadbee*0x10000000 = 0x00deadbe_e0000000 and 0xdeadbeef*0x10000000 = 0xfdeadbee_f0000000 -> every result reaches the correct port in order; the bench's done flag asserts.
5. Hold resp0_rdy=0 for 20 cycles with the response pending -> mulresp_rdy=0, busy=1, req0_rdy=req1_rdy=0 for all 20 cycles; the result delivers once rdy rises.
6. Assert reset=0 during WAIT -> busy, mulreq_val, resp*_val, req*_rdy go to 0 immediately; after release, port 0 wins the first tie.
